// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle RV32 sequencing controller.
// Contents: state encodings, opcode constants, ALU operation codes,
// PC source codes, trap cause codes and the DECODE dispatch helper.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_IEXEC    = 4'd2,
        S_LUI      = 4'd3,
        S_ALU_WB   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WB   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;

    localparam logic [2:0] F3_BYTE = 3'b000;
    localparam logic [2:0] F3_WORD = 3'b010;

    localparam logic [2:0] ALU_PASS_B = 3'b000;
    localparam logic [2:0] ALU_BRANCH = 3'b001;
    localparam logic [2:0] ALU_LOAD   = 3'b010;
    localparam logic [2:0] ALU_STORE  = 3'b011;
    localparam logic [2:0] ALU_IMM    = 3'b100;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_IMEM    = 2'b10;
    localparam logic [1:0] CAUSE_DMEM    = 2'b11;

    // First execute state for an instruction; S_TRAP marks it illegal.
    // Only byte and word stores exist on this datapath.
    function automatic state_t decode_dispatch(input logic [6:0] opcode,
                                               input logic [2:0] funct3);
        state_t target;
        target = S_TRAP;
        case (opcode)
            OP_LUI:    target = S_LUI;
            OP_JAL:    target = S_JAL;
            OP_BRANCH: target = S_BRANCH;
            OP_LOAD:   target = S_MEM_ADDR;
            OP_STORE:  target = (funct3 == F3_BYTE || funct3 == F3_WORD) ? S_MEM_ADDR : S_TRAP;
            OP_IMM:    target = S_IEXEC;
            default:   target = S_TRAP;
        endcase
        return target;
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Memory handshake bundle between the controller and the instruction/data
// memories.
//   imem_req   : instruction fetch request (controller -> memory)
//   imem_ready : instruction data valid (memory -> controller)
//   dmem_req   : data access request
//   dmem_we    : data access is a write
//   sb         : data write is a single byte
//   dmem_ready : data access complete
interface multicycle_control_if;
    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_we;
    logic sb;
    logic dmem_ready;

    modport master (
        output imem_req, dmem_req, dmem_we, sb,
        input  imem_ready, dmem_ready
    );

    modport slave (
        input  imem_req, dmem_req, dmem_we, sb,
        output imem_ready, dmem_ready
    );
endinterface

// File: rtl/multicycle_control_mem_watchdog.sv
// Memory-wait watchdog.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : zero the count (state change)
//   enable     : a wait cycle is in progress (request pending, not ready)
//   timeout    : count already at MEM_TIMEOUT and still waiting
// A ready seen while the count sits at MEM_TIMEOUT drops enable, so the
// timeout does not fire and the normal transition wins.
module mem_watchdog #(
    parameter int TIMEOUT_W   = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic timeout
);
    logic [TIMEOUT_W-1:0] count_reg;
    logic [TIMEOUT_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clear)
            count_next = '0;
        else if (enable)
            count_next = count_reg + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count_reg <= '0;
        else
            count_reg <= count_next;
    end

    assign timeout = enable && (count_reg == TIMEOUT_W'(MEM_TIMEOUT));
endmodule

// File: rtl/multicycle_control.sv
// Multicycle sequencing controller for the RV32 datapath.
// Ports: clk/reset; opcode/funct3 from the IR; comp (branch condition);
// mem (handshake bundle, master side); datapath enables ir_write, pc_write,
// opnd_write, reg_write, aluout_write; selects pc_src, alu_src, alu_op,
// mem_to_reg; debug state; sticky trap/trap_cause; retired counter.
// Outputs are decoded from the state; FETCH write enables and the memory
// wait transitions are qualified by the ready inputs.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int TIMEOUT_W   = 4,
    parameter int MEM_TIMEOUT = 15,
    parameter int RETIRE_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic                comp,
    multicycle_control_if.master mem,
    output logic                ir_write,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic                opnd_write,
    output logic                reg_write,
    output logic                alu_src,
    output logic [2:0]          alu_op,
    output logic                aluout_write,
    output logic                mem_to_reg,
    output logic [3:0]          state,
    output logic                trap,
    output logic [1:0]          trap_cause,
    output logic [RETIRE_W-1:0] retired
);
    state_t              state_reg, state_next;
    logic                trap_reg;
    logic [1:0]          trap_cause_reg, cause_next;
    logic [RETIRE_W-1:0] retired_reg;
    logic                retire;
    logic                wd_enable, wd_timeout;
    logic                imem_req, dmem_req, dmem_we, sb;

    mem_watchdog #(
        .TIMEOUT_W   (TIMEOUT_W),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_next != state_reg),
        .enable  (wd_enable),
        .timeout (wd_timeout)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= S_FETCH;
            trap_reg       <= 1'b0;
            trap_cause_reg <= CAUSE_NONE;
            retired_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (state_next == S_TRAP && state_reg != S_TRAP) begin
                trap_reg       <= 1'b1;
                trap_cause_reg <= cause_next;
            end
            if (retire)
                retired_reg <= retired_reg + 1'b1;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cause_next   = CAUSE_NONE;
        retire       = 1'b0;
        wd_enable    = 1'b0;
        imem_req     = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = PC_PLUS4;
        opnd_write   = 1'b0;
        reg_write    = 1'b0;
        alu_src      = 1'b0;
        alu_op       = ALU_PASS_B;
        aluout_write = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        sb           = 1'b0;
        mem_to_reg   = 1'b0;
        case (state_reg)
            S_FETCH: begin
                imem_req  = 1'b1;
                wd_enable = !mem.imem_ready;
                if (mem.imem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = S_DECODE;
                end else if (wd_timeout) begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_IMEM;
                end
            end
            S_DECODE: begin
                opnd_write = 1'b1;
                state_next = decode_dispatch(opcode, funct3);
                cause_next = CAUSE_ILLEGAL;
            end
            S_IEXEC: begin
                alu_src      = 1'b1;
                alu_op       = ALU_IMM;
                aluout_write = 1'b1;
                state_next   = S_ALU_WB;
            end
            S_LUI: begin
                alu_src      = 1'b1;
                alu_op       = ALU_PASS_B;
                aluout_write = 1'b1;
                state_next   = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write  = 1'b1;
                state_next = S_FETCH;
                retire     = 1'b1;
            end
            S_MEM_ADDR: begin
                alu_src      = 1'b1;
                aluout_write = 1'b1;
                if (opcode == OP_STORE) begin
                    alu_op     = ALU_STORE;
                    state_next = S_MEM_WR;
                end else begin
                    alu_op     = ALU_LOAD;
                    state_next = S_MEM_RD;
                end
            end
            S_MEM_RD: begin
                dmem_req  = 1'b1;
                wd_enable = !mem.dmem_ready;
                if (mem.dmem_ready) begin
                    state_next = S_MEM_WB;
                end else if (wd_timeout) begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_DMEM;
                end
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_next = S_FETCH;
                retire     = 1'b1;
            end
            S_MEM_WR: begin
                dmem_req  = 1'b1;
                dmem_we   = 1'b1;
                sb        = (funct3 == F3_BYTE);
                wd_enable = !mem.dmem_ready;
                if (mem.dmem_ready) begin
                    state_next = S_FETCH;
                    retire     = 1'b1;
                end else if (wd_timeout) begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_DMEM;
                end
            end
            S_BRANCH: begin
                alu_op     = ALU_BRANCH;
                pc_src     = PC_BRANCH;
                pc_write   = comp;
                state_next = S_FETCH;
                retire     = 1'b1;
            end
            S_JAL: begin
                pc_src     = PC_JUMP;
                pc_write   = 1'b1;
                state_next = S_FETCH;
                retire     = 1'b1;
            end
            S_TRAP: begin
                state_next = S_TRAP;
            end
            default: begin
                state_next = S_TRAP;
                cause_next = CAUSE_ILLEGAL;
            end
        endcase
    end

    assign mem.imem_req = imem_req;
    assign mem.dmem_req = dmem_req;
    assign mem.dmem_we  = dmem_we;
    assign mem.sb       = sb;

    assign state      = state_reg;
    assign trap       = trap_reg;
    assign trap_cause = trap_cause_reg;
    assign retired    = retired_reg;
endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  opcode = 7'd0;
    logic [2:0]  funct3 = 3'd0;
    logic        comp = 1'b0;
    logic        ir_write, pc_write, opnd_write, reg_write, alu_src;
    logic        aluout_write, mem_to_reg, trap;
    logic [1:0]  pc_src, trap_cause;
    logic [2:0]  alu_op;
    logic [3:0]  state;
    logic [15:0] retired;
    int compared = 0;
    int mismatched = 0;

    multicycle_control_if mem_bus();

    multicycle_control #(.TIMEOUT_W(4), .MEM_TIMEOUT(15), .RETIRE_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .funct3       (funct3),
        .comp         (comp),
        .mem          (mem_bus),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .opnd_write   (opnd_write),
        .reg_write    (reg_write),
        .alu_src      (alu_src),
        .alu_op       (alu_op),
        .aluout_write (aluout_write),
        .mem_to_reg   (mem_to_reg),
        .state        (state),
        .trap         (trap),
        .trap_cause   (trap_cause),
        .retired      (retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive an instruction through FETCH with zero-wait imem, ending in DECODE.
    task automatic fetch(input logic [6:0] op, input logic [2:0] f3);
        opcode = op;
        funct3 = f3;
        mem_bus.imem_ready = 1'b1;
        #1;
        chk("fetch_ir_write", ir_write, 1'b1);
        tick();
        mem_bus.imem_ready = 1'b0;
        chk("decode_state", state, 4'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        tick();
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        mem_bus.imem_ready = 1'b0;
        mem_bus.dmem_ready = 1'b0;
        #3;
        chk("rst_state", state, 4'd0);
        chk("rst_imem_req", mem_bus.imem_req, 1'b1);
        chk("rst_retired", retired, 16'd0);
        chk("rst_trap", {trap, trap_cause}, 3'b000);
        chk("rst_ir_write", ir_write, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;

        // I-type: 0,1,2,4,0
        fetch(7'b0010011, 3'b000);
        chk("itype_pcsrc_opnd", {pc_src, opnd_write, reg_write}, 4'b0010);
        tick();
        chk("itype_iexec", {state, alu_src, alu_op, aluout_write, reg_write}, {4'd2, 1'b1, 3'b100, 1'b1, 1'b0});
        tick();
        chk("itype_wb", {state, reg_write, mem_to_reg}, {4'd4, 1'b1, 1'b0});
        tick();
        chk("itype_done", {state, reg_write}, {4'd0, 1'b0});
        chk("itype_retired", retired, 16'd1);
        $display("txn itype: state=%0d retired=%0d", state, retired);

        // Load, dmem_ready delayed 3 cycles
        fetch(7'b0000011, 3'b010);
        tick();
        chk("load_addr", {state, alu_src, alu_op}, {4'd5, 1'b1, 3'b010});
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("load_rd_wait", {state, mem_bus.dmem_req, mem_bus.dmem_we}, {4'd6, 2'b10});
            tick();
        end
        chk("load_rd_last", {state, mem_bus.dmem_req}, {4'd6, 1'b1});
        mem_bus.dmem_ready = 1'b1;
        tick();
        mem_bus.dmem_ready = 1'b0;
        chk("load_wb", {state, reg_write, mem_to_reg}, {4'd7, 2'b11});
        tick();
        chk("load_retired", {state, retired}, {4'd0, 16'd2});
        $display("txn load: state=%0d retired=%0d", state, retired);

        // Store byte, zero wait
        fetch(7'b0100011, 3'b000);
        tick();
        chk("sb_addr", {state, alu_op}, {4'd5, 3'b011});
        mem_bus.dmem_ready = 1'b1;
        tick();
        chk("sb_wr", {state, mem_bus.dmem_req, mem_bus.dmem_we, mem_bus.sb, reg_write}, {4'd8, 4'b1110});
        tick();
        mem_bus.dmem_ready = 1'b0;
        chk("sb_retired", {state, retired}, {4'd0, 16'd3});
        $display("txn store_byte: state=%0d retired=%0d", state, retired);

        // Branch taken then not taken
        comp = 1'b1;
        fetch(7'b1100011, 3'b000);
        tick();
        chk("br_taken", {state, pc_src, pc_write, alu_op, alu_src}, {4'd9, 2'b01, 1'b1, 3'b001, 1'b0});
        tick();
        chk("br_taken_ret", {state, retired}, {4'd0, 16'd4});
        comp = 1'b0;
        fetch(7'b1100011, 3'b001);
        tick();
        chk("br_not_taken", {state, pc_src, pc_write}, {4'd9, 2'b01, 1'b0});
        tick();
        chk("br_nt_ret", retired, 16'd5);
        $display("txn branch: state=%0d retired=%0d", state, retired);

        // JAL and LUI
        fetch(7'b1101111, 3'b000);
        tick();
        chk("jal", {state, pc_src, pc_write, reg_write}, {4'd10, 2'b10, 1'b1, 1'b0});
        tick();
        chk("jal_ret", {state, retired}, {4'd0, 16'd6});
        fetch(7'b0110111, 3'b000);
        tick();
        chk("lui", {state, alu_src, alu_op, aluout_write}, {4'd3, 1'b1, 3'b000, 1'b1});
        tick();
        chk("lui_wb", {state, reg_write}, {4'd4, 1'b1});
        tick();
        chk("lui_ret", {state, retired}, {4'd0, 16'd7});
        $display("txn jal_lui: state=%0d retired=%0d", state, retired);

        // Load: ready arriving at count==MEM_TIMEOUT wins over the trap
        fetch(7'b0000011, 3'b000);
        tick();
        tick();
        for (int i = 0; i < 15; i++) tick();
        chk("wd_edge_still_rd", {state, trap}, {4'd6, 1'b0});
        mem_bus.dmem_ready = 1'b1;
        tick();
        mem_bus.dmem_ready = 1'b0;
        chk("wd_edge_ready_wins", {state, trap}, {4'd7, 1'b0});
        tick();
        chk("wd_edge_ret", retired, 16'd8);
        $display("txn load_edge: state=%0d retired=%0d", state, retired);

        // Reset during MEM_WR with dmem_ready low
        fetch(7'b0100011, 3'b010);
        tick();
        tick();
        chk("sw_wr", {state, mem_bus.dmem_req, mem_bus.sb}, {4'd8, 1'b1, 1'b0});
        reset = 1'b1;
        #1;
        chk("rst_mid", {state, mem_bus.dmem_req, mem_bus.imem_req, reg_write}, {4'd0, 1'b0, 1'b1, 1'b0});
        chk("rst_mid_retired", retired, 16'd0);
        $display("txn reset_mid: state=%0d retired=%0d", state, retired);
        tick();
        @(negedge clk);
        reset = 1'b0;
        #1;

        // imem timeout: 15 counted wait cycles, trap on the next one
        for (int i = 0; i < 15; i++) tick();
        chk("imem_wait_edge", {state, trap}, {4'd0, 1'b0});
        tick();
        chk("imem_trap", {state, trap, trap_cause}, {4'd15, 1'b1, 2'b10});
        mem_bus.imem_ready = 1'b1;
        tick();
        tick();
        chk("imem_trap_hold", {state, trap, trap_cause, mem_bus.imem_req, ir_write}, {4'd15, 1'b1, 2'b10, 2'b00});
        mem_bus.imem_ready = 1'b0;
        $display("txn imem_timeout: state=%0d cause=%0d", state, trap_cause);

        // Illegal opcode (R-type not supported)
        do_reset();
        chk("post_rst_trap", {state, trap, trap_cause}, {4'd0, 3'b000});
        fetch(7'b0110011, 3'b000);
        tick();
        chk("illegal_trap", {state, trap, trap_cause}, {4'd15, 1'b1, 2'b01});
        tick();
        chk("illegal_hold", {state, trap, trap_cause, mem_bus.imem_req}, {4'd15, 1'b1, 2'b01, 1'b0});
        $display("txn illegal: state=%0d cause=%0d", state, trap_cause);

        // Halfword store is not supported
        do_reset();
        fetch(7'b0100011, 3'b001);
        tick();
        chk("sh_illegal", {state, trap_cause}, {4'd15, 2'b01});
        $display("txn store_half: state=%0d cause=%0d", state, trap_cause);

        // dmem timeout on a store
        do_reset();
        fetch(7'b0100011, 3'b000);
        tick();
        tick();
        for (int i = 0; i < 15; i++) tick();
        chk("dmem_wait_edge", {state, trap}, {4'd8, 1'b0});
        tick();
        chk("dmem_trap", {state, trap, trap_cause, mem_bus.dmem_req}, {4'd15, 1'b1, 2'b11, 1'b0});
        chk("dmem_trap_ret", retired, 16'd0);
        $display("txn dmem_timeout: state=%0d cause=%0d", state, trap_cause);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
